// File: rtl/rx_iq_packer_pkg.sv
// Shared constants and types for the I/Q byte packer.
// FSM encodings are plain localparams so older code that compares raw state values still works.
package rx_iq_packer_pkg;

  localparam int BYTES_PER_PAIR = 6;
  localparam int PAIR_WIDTH     = 48;
  localparam int IQ_WIDTH       = 24;
  localparam int DROPCNT_WIDTH  = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;

  // One FIFO entry: I in the upper half so it is serialised first.
  typedef struct packed {
    logic [IQ_WIDTH-1:0] i;
    logic [IQ_WIDTH-1:0] q;
  } iq_pair_t;

  // Saturating increment for the dropped-sample counter.
  function automatic logic [DROPCNT_WIDTH-1:0] sat_inc(input logic [DROPCNT_WIDTH-1:0] v);
    sat_inc = (v == {DROPCNT_WIDTH{1'b1}}) ? v : v + {{(DROPCNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/rx_iq_fifo.sv
// Single-clock FIFO of I/Q pairs. A push while full is still taken when a pop happens in the
// same cycle, because the slot being read is free by the time the write lands.
module rx_iq_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 48
) (
  input  logic                     clock,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == DEPTH[AW:0]);
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  // Storage write; contents need no reset since count gates every read.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers (wrap modulo DEPTH) and occupancy.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rx_iq_packer.sv
// Packs decimated 24b I/Q pairs into 6 bytes (I MSB first, then Q) for the packet formatter.
// Optional feature macro: RX_IQ_PACKER_DROPCNT_EN adds a saturating 16b drop_count output.
//
// Byte handshake: a byte transfers on a rising clock edge where out_valid & out_ready are both
// high; once out_valid rises, out_valid and out_data hold unchanged until that transfer.
module rx_iq_packer
  import rx_iq_packer_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int SAMPLE_WIDTH = 24
) (
  input  logic                     clock,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     in_strobe,
  input  logic [SAMPLE_WIDTH-1:0]  in_i,
  input  logic [SAMPLE_WIDTH-1:0]  in_q,
  output logic [7:0]               out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic                     overflow,
  input  logic                     clear_overflow,
  output logic [1:0]               fsm_state
`ifdef RX_IQ_PACKER_DROPCNT_EN
  ,
  output logic [DROPCNT_WIDTH-1:0] drop_count
`endif
);

  localparam logic [2:0] LAST_IDX = 3'(BYTES_PER_PAIR - 1);

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic [PAIR_WIDTH-1:0] shreg;
  logic [2:0]            byte_idx;
  iq_pair_t              wr_pair;
  logic [PAIR_WIDTH-1:0] rd_pair;
  logic                  push_req;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  load_now;
  logic                  byte_fire;
  logic                  last_fire;
  logic                  drop;

  assign wr_pair.i = in_i;
  assign wr_pair.q = in_q;
  assign push_req  = in_strobe && enable;

  // IDLE loads directly so a sample reaches the wire two cycles after its strobe;
  // LOAD is the one-cycle refill between back-to-back pairs.
  assign load_now  = !fifo_empty && ((state == ST_IDLE) || (state == ST_LOAD));
  assign byte_fire = (state == ST_SEND) && out_ready;
  assign last_fire = byte_fire && (byte_idx == LAST_IDX);
  assign drop      = push_req && fifo_full && !load_now;

  assign out_valid = (state == ST_SEND);
  assign out_data  = (state == ST_SEND) ? shreg[PAIR_WIDTH-1 -: 8] : 8'h00;
  assign out_last  = (state == ST_SEND) && (byte_idx == LAST_IDX);
  assign fsm_state = state;

  rx_iq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PAIR_WIDTH)
  ) u_fifo (
    .clock     (clock),
    .rst_n     (rst_n),
    .push      (push_req),
    .push_data (wr_pair),
    .pop       (load_now),
    .pop_data  (rd_pair),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fill_level)
  );

  // Next-state decode for the serialiser.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (load_now) state_nxt = ST_SEND;
      ST_LOAD: state_nxt = load_now ? ST_SEND : ST_IDLE;
      ST_SEND: if (last_fire) state_nxt = fifo_empty ? ST_IDLE : ST_LOAD;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, shift register and byte index; shifting left keeps the current byte at the top.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      byte_idx <= '0;
    end else begin
      state <= state_nxt;
      if (load_now) begin
        shreg    <= rd_pair;
        byte_idx <= '0;
      end else if (byte_fire) begin
        shreg    <= {shreg[PAIR_WIDTH-9:0], 8'h00};
        byte_idx <= byte_idx + 3'd1;
      end
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n)              overflow <= 1'b0;
    else if (drop)           overflow <= 1'b1;
    else if (clear_overflow) overflow <= 1'b0;
  end

`ifdef RX_IQ_PACKER_DROPCNT_EN
  // Dropped-sample counter; a clear coincident with a drop restarts the count at one.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      drop_count <= '0;
    end else if (drop) begin
      drop_count <= clear_overflow ? {{(DROPCNT_WIDTH-1){1'b0}}, 1'b1} : sat_inc(drop_count);
    end else if (clear_overflow) begin
      drop_count <= '0;
    end
  end
`endif

endmodule
